// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
//
// Converts the one-cycle-latency read port of an upstream FIFO into a
// valid/ready stream. A two-entry buffer (head, tail) absorbs the read
// latency so the stream can move one entry per clock in steady state while
// never over-committing: a read is only requested when the buffer is
// guaranteed to have room for the returning word.
//
// Optional feature (compile-time macro):
//   FIFO_RD_STREAM_ERR_CHK_EN  - when defined, an upstream ack that arrives
//                                with no read outstanding sets the sticky
//                                o_err flag. When undefined, o_err is tied
//                                low and stray acks are silently dropped.
//
// Parameters:
//   WIDTH            data width of one entry (must match the upstream FIFO)
//
// Ports:
//   i_clk            clock, all state updates on the rising edge
//   i_rst_n          asynchronous active-low reset
//   i_flush          synchronous flush, shared with the upstream FIFO
//   i_fifo_r_avail   upstream FIFO holds at least one entry
//   o_fifo_r_e       read request to the upstream FIFO
//   i_fifo_r_ack     read issued last cycle was accepted; data valid now
//   i_fifo_r_data    upstream read data
//   o_valid          o_data holds a valid entry
//   o_data           head entry (held, not X, while o_valid is low)
//   i_ready          downstream accepts the head entry this cycle
//   o_count          number of buffered entries, 0..2
//   o_err            sticky protocol error flag
// -----------------------------------------------------------------------------
module fifo_rd_stream #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_fifo_r_avail,
  output logic             o_fifo_r_e,
  input  logic             i_fifo_r_ack,
  input  logic [WIDTH-1:0] i_fifo_r_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready,
  output logic [1:0]       o_count,
  output logic             o_err
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]       count_reg;
  logic [1:0]       count_next;
  logic             inflight_reg;
  logic             inflight_next;
  logic [WIDTH-1:0] head_reg;
  logic [WIDTH-1:0] head_next;
  logic [WIDTH-1:0] tail_reg;
  logic [WIDTH-1:0] tail_next;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] occupancy;

  assign o_valid = (count_reg != 2'd0);
  assign pop     = o_valid & i_ready;

  // An ack only carries data if we actually asked for it last cycle; a flush
  // in the same cycle discards the returning word.
  assign push = i_fifo_r_ack & inflight_reg & ~i_flush;

  // Entries already buffered plus the one on its way, minus the one leaving
  // this cycle. Widened to 3 bits so the sum cannot wrap; pop implies
  // count >= 1, so the subtraction never underflows.
  assign occupancy = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};

  // The pop term makes this combinational from i_ready on purpose: freeing a
  // slot and refilling it in the same cycle keeps a full-rate stream with
  // only two entries of storage. i_rst_n gates the request so that nothing
  // is asked of the upstream FIFO while reset is held.
  assign issue = i_rst_n & i_fifo_r_avail & ~i_flush & (occupancy < 3'd2);

  assign o_fifo_r_e = issue;

  // ---------------------------------------------------------------------------
  // Buffer next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    count_next    = count_reg;
    head_next     = head_reg;
    tail_next     = tail_reg;
    inflight_next = issue;

    if (i_flush) begin
      // Flush wins over ack, pop and issue. Data registers keep their stale
      // contents; they are invisible once count is zero.
      count_next    = 2'd0;
      inflight_next = 1'b0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          // Push only.
          unique case (count_reg)
            2'd0: begin
              head_next  = i_fifo_r_data;
              count_next = 2'd1;
            end
            2'd1: begin
              tail_next  = i_fifo_r_data;
              count_next = 2'd2;
            end
            default: begin
              // Full buffer cannot receive a push because a read is never
              // issued without room; hold state if it ever happens.
              count_next = count_reg;
            end
          endcase
        end
        2'b11: begin
          // Push and pop together; count is unchanged.
          if (count_reg == 2'd1) begin
            head_next = i_fifo_r_data;
          end else begin
            // Count 2: shift tail forward and refill tail. Unreachable given
            // the issue rule, but kept so ordering survives any corner case.
            head_next = tail_reg;
            tail_next = i_fifo_r_data;
          end
        end
        2'b01: begin
          // Pop only. Shifting an unused tail into head is harmless.
          head_next  = tail_reg;
          count_next = count_reg - 2'd1;
        end
        default: begin
          count_next = count_reg;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_reg    <= 2'd0;
      inflight_reg <= 1'b0;
      head_reg     <= '0;
      tail_reg     <= '0;
    end else begin
      count_reg    <= count_next;
      inflight_reg <= inflight_next;
      head_reg     <= head_next;
      tail_reg     <= tail_next;
    end
  end

  assign o_data  = head_reg;
  assign o_count = count_reg;

  // ---------------------------------------------------------------------------
  // Protocol error detection
  // ---------------------------------------------------------------------------
`ifdef FIFO_RD_STREAM_ERR_CHK_EN
  logic err_reg;
  logic err_next;
  logic stray_ack;

  // An ack with nothing outstanding means the upstream and this block
  // disagree on the read protocol. The word is dropped (push requires
  // inflight) and the condition is latched until reset; flush does not
  // clear it.
  assign stray_ack = i_fifo_r_ack & ~inflight_reg;
  assign err_next  = err_reg | stray_ack;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= err_next;
    end
  end

  assign o_err = err_reg;
`else
  // Checking compiled out: stray acks are still dropped by the push rule,
  // they just are not reported.
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_stream
//
// Directed bench for fifo_rd_stream. A tiny upstream responder returns an ack
// with the next data word one cycle after each read request. Inputs change
// 1 ns after the rising edge and outputs are sampled 2 ns after it.
// Expected values below are worked out by hand from the cycle behaviour.
// -----------------------------------------------------------------------------
module tb_fifo_rd_stream;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             avail;
  logic             rd_en;
  logic             ack;
  logic [WIDTH-1:0] rdata;
  logic             valid;
  logic [WIDTH-1:0] data;
  logic             ready;
  logic [1:0]       count;
  logic             err;

  int checks;
  int passes;
  int issues;

  // Upstream responder control.
  logic             auto_ack;
  logic [WIDTH-1:0] nxt_data;
  logic [31:0]      exp_err;

  fifo_rd_stream #(.WIDTH(WIDTH)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_flush        (flush),
    .i_fifo_r_avail (avail),
    .o_fifo_r_e     (rd_en),
    .i_fifo_r_ack   (ack),
    .i_fifo_r_data  (rdata),
    .o_valid        (valid),
    .o_data         (data),
    .i_ready        (ready),
    .o_count        (count),
    .o_err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      passes++;
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance one clock. The read request seen just before the edge decides
  // whether the responder acks with fresh data just after it.
  task automatic tick();
    logic re_seen;
    #1;
    re_seen = rd_en;
    @(posedge clk);
    #1;
    if (auto_ack) begin
      ack = re_seen;
      if (re_seen) begin
        rdata    = nxt_data;
        nxt_data = nxt_data + 1;
      end
    end
    #1;
  endtask

  initial begin
    checks   = 0;
    passes   = 0;
    issues   = 0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    avail    = 1'b0;
    ack      = 1'b0;
    rdata    = '0;
    ready    = 1'b0;
    auto_ack = 1'b1;
    nxt_data = 32'h1;
`ifdef FIFO_RD_STREAM_ERR_CHK_EN
    exp_err = 32'd1;
`else
    exp_err = 32'd0;
`endif

    // ---------------- Reset state ----------------
    repeat (2) @(posedge clk);
    #2;
    avail = 1'b1;
    #1;
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_count", {30'd0, count}, 32'd0);
    check("rst_data",  data,           32'd0);
    check("rst_rd_en", {31'd0, rd_en}, 32'd0);
    check("rst_err",   {31'd0, err},   32'd0);
    avail = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;

    // ---------------- Scenario 1: streaming ----------------
    avail = 1'b1;
    ready = 1'b1;
    #1;
    check("s1_c0_rd_en", {31'd0, rd_en}, 32'd1);
    tick();
    check("s1_c1_valid", {31'd0, valid}, 32'd0);
    tick();
    check("s1_c2_valid", {31'd0, valid}, 32'd1);
    check("s1_c2_data",  data,           32'h1);
    tick();
    check("s1_c3_data",  data,           32'h2);
    check("s1_c3_count", {30'd0, count}, 32'd1);
    tick();
    check("s1_c4_data",  data,           32'h3);
    avail = 1'b0;
    tick();
    check("s1_c5_data",  data,           32'h4);
    tick();
    check("s1_c6_valid", {31'd0, valid}, 32'd0);

    // ---------------- Scenario 2: back-pressure ----------------
    ready    = 1'b0;
    avail    = 1'b1;
    nxt_data = 32'h10;
    #1;
    for (int i = 0; i < 5; i++) begin
      if (rd_en) issues++;
      tick();
    end
    check("s2_issues",  issues,         32'd2);
    check("s2_count",   {30'd0, count}, 32'd2);
    check("s2_rd_en",   {31'd0, rd_en}, 32'd0);
    check("s2_head",    data,           32'h10);
    ready = 1'b1;
    #1;
    check("s2_resume_rd_en", {31'd0, rd_en}, 32'd1);
    tick();
    check("s2_d1_data",  data,           32'h11);
    check("s2_d1_count", {30'd0, count}, 32'd1);
    avail = 1'b0;
    tick();
    check("s2_d2_data",  data,           32'h12);
    check("s2_d2_count", {30'd0, count}, 32'd1);
    tick();
    check("s2_empty",    {31'd0, valid}, 32'd0);

    // ---------------- Scenario 3: flush on ack ----------------
    ready    = 1'b0;
    avail    = 1'b1;
    nxt_data = 32'h20;
    tick();               // issue 0x20 went out, ack now present
    tick();               // 0x20 pushed, ack of 0x21 now present
    check("s3_pre_count", {30'd0, count}, 32'd1);
    check("s3_pre_ack",   {31'd0, ack},   32'd1);
    flush = 1'b1;
    avail = 1'b0;
    #1;
    check("s3_flush_rd_en", {31'd0, rd_en}, 32'd0);
    tick();
    flush = 1'b0;
    ready = 1'b1;
    #1;
    check("s3_count", {30'd0, count}, 32'd0);
    check("s3_valid", {31'd0, valid}, 32'd0);
    tick();
    check("s3_still_empty", {31'd0, valid}, 32'd0);
    check("s3_err",         {31'd0, err},   32'd0);

    // ---------------- Scenario 4: stray ack ----------------
    auto_ack = 1'b0;
    ack      = 1'b1;
    rdata    = 32'h55;
    tick();
    ack = 1'b0;
    #1;
    check("s4_err",   {31'd0, err},   exp_err);
    check("s4_count", {30'd0, count}, 32'd0);
    tick();
    check("s4_err_held", {31'd0, err}, exp_err);
    check("s4_valid",    {31'd0, valid}, 32'd0);
    auto_ack = 1'b1;

    // ---------------- Scenario 5: async reset mid-stream ----------------
    ready    = 1'b0;
    avail    = 1'b1;
    nxt_data = 32'h30;
    repeat (4) tick();
    check("s5_full", {30'd0, count}, 32'd2);
    rst_n = 1'b0;
    #1;
    check("s5_rst_valid", {31'd0, valid}, 32'd0);
    check("s5_rst_count", {30'd0, count}, 32'd0);
    check("s5_rst_data",  data,           32'd0);
    check("s5_rst_rd_en", {31'd0, rd_en}, 32'd0);
    check("s5_rst_err",   {31'd0, err},   32'd0);
    avail = 1'b0;
    ready = 1'b1;
    tick();
    rst_n = 1'b1;
    #1;
    avail    = 1'b1;
    nxt_data = 32'hA5;
    #1;
    check("s5_issue", {31'd0, rd_en}, 32'd1);
    tick();
    avail = 1'b0;
    check("s5_n1_valid", {31'd0, valid}, 32'd0);
    tick();
    check("s5_n2_valid", {31'd0, valid}, 32'd1);
    check("s5_n2_data",  data,           32'hA5);
    tick();
    check("s5_drained",  {31'd0, valid}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
